// File: rtl/pwm_fader_multi.sv
// pwm_fader_multi - multi-channel LED dimmer with per-channel fade engine.
//
// Each channel owns a target and a level register. A write either snaps the
// level to the new target or lets it fade there one LSB per prescaler tick.
// The level (or its gamma-corrected value) drives a first-order accumulator
// modulator whose carry-out is the LED pin.
//
// Optional build macro:
//   PWM_FADER_GAMMA_EN - square-law perceptual curve, eff = (l*(l+1)) >> W.
//                        Undefined: eff = level, no multiplier.
//
// Parameters:
//   CH        number of channels (1..16)
//   W         brightness resolution in bits (2..16)
//   RAMP_DIV  clk cycles per fade step (>=1)
//   CHW       width of wr_ch, 2**CHW >= CH
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   wr_en     single-cycle write strobe
//   wr_ch     channel index of the write (indices >= CH are ignored)
//   wr_level  new target brightness
//   wr_ramp   1 = fade to target, 0 = apply immediately
//   led       registered modulator outputs, bit i = channel i
//   settled   bit i high when level[i] == target[i]
//
// Ramp state per channel (derived from level vs target):
//   state | meaning
//   IDLE  | level == target, hold
//   UP    | level <  target, +1 on tick
//   DOWN  | level >  target, -1 on tick

module pwm_fader_multi #(
  parameter int CH       = 4,
  parameter int W        = 8,
  parameter int RAMP_DIV = 1000,
  parameter int CHW      = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [W-1:0]   wr_level,
  input  logic           wr_ramp,
  output logic [CH-1:0]  led,
  output logic [CH-1:0]  settled
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_st_t;

  logic [PW-1:0] presc;
  logic          tick;

  logic [W-1:0]  target [CH];
  logic [W-1:0]  level  [CH];
  logic [W:0]    acc    [CH];
  logic [W-1:0]  eff    [CH];
  ramp_st_t      st     [CH];
`ifdef PWM_FADER_GAMMA_EN
  logic [W2-1:0] prod   [CH];
`endif

  assign tick = (presc == PW'(RAMP_DIV - 1));

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      st[i] = IDLE;
      if (level[i] < target[i])
        st[i] = UP;
      else if (level[i] > target[i])
        st[i] = DOWN;

`ifdef PWM_FADER_GAMMA_EN
      // level*(level+1) never exceeds 2W bits, and the top W bits map
      // full scale to full scale and zero to zero.
      prod[i] = W2'(level[i]) * (W2'(level[i]) + W2'(1));
      eff[i]  = W'(prod[i] >> W);
`else
      eff[i]  = level[i];
`endif

      settled[i] = (level[i] == target[i]);
      // Carry of the last accumulator update is kept in acc[W], so the
      // pin comes straight from a flop.
      led[i]     = acc[i][W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc <= '0;
      for (int i = 0; i < CH; i++) begin
        target[i] <= '0;
        level[i]  <= '0;
        acc[i]    <= '0;
      end
    end else begin
      presc <= tick ? '0 : presc + PW'(1);

      for (int i = 0; i < CH; i++) begin
        // acc is never touched by writes so a level change cannot glitch
        acc[i] <= {1'b0, acc[i][W-1:0]} + {1'b0, eff[i]};

        // Step decision uses the registered target; a same-cycle ramp
        // write only changes the target seen from the next cycle.
        if (tick) begin
          case (st[i])
            UP:      level[i] <= level[i] + W'(1);
            DOWN:    level[i] <= level[i] - W'(1);
            default: level[i] <= level[i];
          endcase
        end

        // Indices >= CH never match any channel, so those writes drop.
        if (wr_en && (wr_ch == CHW'(i))) begin
          target[i] <= wr_level;
          if (!wr_ramp)
            level[i] <= wr_level;   // overrides the tick step above
        end
      end
    end
  end

endmodule
